// File: rtl/pi_loop_sequencer.sv
// -----------------------------------------------------------------------------
// pi_loop_sequencer
//   Supervisor and sequencer for one axis_pi regulator.
//   - Generates the PI sampling strobe from a programmable prescaler.
//   - Forwards the latest ADC feedback sample and a slew-limited reference.
//   - Holds the PI in reset except while RAMP or RUN.
//   - Trips to FAULT when the PI output stays saturated for too many samples.
//
// Ports
//   aclk, resetn                 clock, synchronous active-low reset
//   enable, fault_clear          loop run request / FAULT acknowledge (needs enable=0)
//   sample_period                strobe every sample_period+1 cycles
//   ref_target, ref_step         final reference, max change per sample (0 = no ramp)
//   sat_timeout                  saturated samples before FAULT (0 = disabled)
//   output_max, output_min       PI output limits, used for saturation detection
//   s_axis_feedback_*            ADC feedback stream, always accepted
//   pi_output                    PI output sample
//   pi_resetn                    reset to the PI instance
//   m_axis_pi_*                  feedback/reference samples to the PI (shared tvalid)
//   state, fault                 FSM state code and FAULT flag
// -----------------------------------------------------------------------------
module pi_loop_sequencer #(
  parameter int inout_width       = 12,
  parameter int prescaler_width   = 16,
  parameter int sat_timeout_width = 16,
  parameter int clear_cycles      = 4
) (
  input  logic                                aclk,
  input  logic                                resetn,
  input  logic                                enable,
  input  logic                                fault_clear,
  input  logic        [prescaler_width-1:0]   sample_period,
  input  logic signed [inout_width-1:0]       ref_target,
  input  logic        [inout_width-1:0]       ref_step,
  input  logic        [sat_timeout_width-1:0] sat_timeout,
  input  logic signed [inout_width-1:0]       output_max,
  input  logic signed [inout_width-1:0]       output_min,
  input  logic signed [inout_width-1:0]       s_axis_feedback_tdata,
  input  logic                                s_axis_feedback_tvalid,
  output logic                                s_axis_feedback_tready,
  input  logic signed [inout_width-1:0]       pi_output,
  output logic                                pi_resetn,
  output logic        [inout_width-1:0]       m_axis_pi_input_tdata,
  output logic        [inout_width-1:0]       m_axis_pi_reference_tdata,
  output logic                                m_axis_pi_tvalid,
  output logic        [2:0]                   state,
  output logic                                fault
);

  localparam int EW = inout_width + 1;
  localparam int SW = sat_timeout_width;
  localparam int CW = (clear_cycles > 1) ? $clog2(clear_cycles) : 1;
  localparam logic [CW-1:0] CLEAR_LAST = CW'(clear_cycles - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_RAMP  = 3'd2,
    ST_RUN   = 3'd3,
    ST_FAULT = 3'd4
  } state_e;

  state_e                      state_q, state_d;
  logic [prescaler_width-1:0]  presc_q, presc_d;
  logic [CW-1:0]               clear_cnt_q, clear_cnt_d;
  logic signed [inout_width-1:0] ref_q, ref_d;
  logic signed [inout_width-1:0] fb_q, fb_d;
  logic [SW-1:0]               sat_cnt_q, sat_cnt_d;
  logic                        tvalid_q, tvalid_d;
  logic [inout_width-1:0]      in_data_q, in_data_d;
  logic [inout_width-1:0]      ref_data_q, ref_data_d;
  logic                        pi_resetn_q, fault_q;

  logic                        tick;
  logic                        sat_hit;
  logic [SW:0]                 sat_plus1;
  logic signed [EW-1:0]        diff_ext;
  logic [EW-1:0]               diff_abs;
  logic signed [inout_width-1:0] ramp_ref;

  assign s_axis_feedback_tready = 1'b1;

  assign tick      = (presc_q == sample_period);
  assign sat_hit   = (pi_output == output_max) || (pi_output == output_min);
  assign sat_plus1 = {1'b0, sat_cnt_q} + (SW + 1)'(1);

  // Slew limiter. The difference is taken one bit wider so that it cannot
  // wrap; when a full step is applied the result lies strictly between ref_q
  // and ref_target, so the narrow add/subtract cannot wrap either.
  always_comb begin
    diff_ext = $signed({ref_target[inout_width-1], ref_target})
             - $signed({ref_q[inout_width-1], ref_q});
    diff_abs = diff_ext[EW-1] ? $unsigned(-diff_ext) : $unsigned(diff_ext);
    if ((ref_step == '0) || (diff_abs <= {1'b0, ref_step})) begin
      ramp_ref = ref_target;
    end else if (diff_ext[EW-1]) begin
      ramp_ref = ref_q - ref_step;
    end else begin
      ramp_ref = ref_q + ref_step;
    end
  end

  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d     = state_q;
    presc_d     = tick ? '0 : presc_q + prescaler_width'(1);
    clear_cnt_d = clear_cnt_q;
    ref_d       = ref_q;
    fb_d        = s_axis_feedback_tvalid ? s_axis_feedback_tdata : fb_q;
    sat_cnt_d   = sat_cnt_q;
    tvalid_d    = 1'b0;
    in_data_d   = in_data_q;
    ref_data_d  = ref_data_q;

    unique case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d     = ST_CLEAR;
          presc_d     = '0;
          clear_cnt_d = '0;
        end
      end
      ST_CLEAR: begin
        clear_cnt_d = clear_cnt_q + CW'(1);
        if (clear_cnt_q == CLEAR_LAST) begin
          state_d = ST_RAMP;
          ref_d   = fb_q;  // bumpless start from the measured value
        end
      end
      ST_RAMP: begin
        if (tick) begin
          ref_d    = ramp_ref;
          tvalid_d = 1'b1;
          if (ramp_ref == ref_target) state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (tick) begin
          if (sat_hit) begin
            sat_cnt_d = (&sat_cnt_q) ? sat_cnt_q : sat_plus1[SW-1:0];
            if ((sat_timeout != '0) && (sat_plus1 >= {1'b0, sat_timeout})) begin
              state_d = ST_FAULT;
            end
          end else begin
            sat_cnt_d = '0;
          end
          if (state_d != ST_FAULT) begin
            tvalid_d = 1'b1;
            if (ref_q != ref_target) begin
              ref_d = ramp_ref;
              if (ramp_ref != ref_target) state_d = ST_RAMP;
            end
          end
        end
      end
      ST_FAULT: begin
        if (!enable && fault_clear) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Dropping enable stops the loop from any state except FAULT, which
    // must be acknowledged explicitly.
    if (!enable && (state_q != ST_FAULT)) state_d = ST_IDLE;

    if (state_d != ST_RUN) sat_cnt_d = '0;

    if (state_d == ST_IDLE) begin
      tvalid_d   = 1'b0;
      ref_d      = '0;
      in_data_d  = '0;
      ref_data_d = '0;
    end

    if (tvalid_d) begin
      in_data_d  = fb_q;
      ref_data_d = ref_d;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge aclk) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      presc_q     <= '0;
      clear_cnt_q <= '0;
      ref_q       <= '0;
      fb_q        <= '0;
      sat_cnt_q   <= '0;
      tvalid_q    <= 1'b0;
      in_data_q   <= '0;
      ref_data_q  <= '0;
      pi_resetn_q <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      clear_cnt_q <= clear_cnt_d;
      ref_q       <= ref_d;
      fb_q        <= fb_d;
      sat_cnt_q   <= sat_cnt_d;
      tvalid_q    <= tvalid_d;
      in_data_q   <= in_data_d;
      ref_data_q  <= ref_data_d;
      // Registered from next state so both are valid in the first cycle
      // of the new state.
      pi_resetn_q <= (state_d == ST_RAMP) || (state_d == ST_RUN);
      fault_q     <= (state_d == ST_FAULT);
    end
  end

  assign pi_resetn                 = pi_resetn_q;
  assign fault                     = fault_q;
  assign m_axis_pi_tvalid          = tvalid_q;
  assign m_axis_pi_input_tdata     = in_data_q;
  assign m_axis_pi_reference_tdata = ref_data_q;
  assign state                     = state_q;

endmodule
